// File: rtl/sum_normalizer.sv
// Divides a widened signed sum by NUM_INPUT (restoring, 1 bit/enabled cycle), rounds, saturates; SUM_W+1 cycles accept->out_valid.
// Single result in flight: in_ready only in IDLE, dout/out_valid hold until out_ready.
module sum_normalizer #(
  parameter int NUM_INPUT     = 2,
  parameter int DATA_WIDTH_IN = 16,
  parameter int ROUND_MODE    = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  ena,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic signed [DATA_WIDTH_IN+$clog2(NUM_INPUT)-1:0]     din,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic signed [DATA_WIDTH_IN-1:0]                       dout,
  output logic                                                  busy
);

  localparam int SUM_W = DATA_WIDTH_IN + $clog2(NUM_INPUT);
  localparam int REM_W = $clog2(NUM_INPUT) + 1;
  localparam int CNT_W = $clog2(SUM_W + 1);

  localparam logic [REM_W:0] DIVISOR = (REM_W+1)'(NUM_INPUT);
  localparam logic [SUM_W:0] POS_LIM = {{(SUM_W+2-DATA_WIDTH_IN){1'b0}}, {(DATA_WIDTH_IN-1){1'b1}}};
  localparam logic [SUM_W:0] NEG_LIM = POS_LIM + (SUM_W+1)'(1);
  localparam logic [DATA_WIDTH_IN-1:0] MAX_OUT = {1'b0, {(DATA_WIDTH_IN-1){1'b1}}};
  localparam logic [DATA_WIDTH_IN-1:0] MIN_OUT = {1'b1, {(DATA_WIDTH_IN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ROUND, OUT} state_t;

  state_t             state;
  logic               neg;
  logic [SUM_W-1:0]   mag;
  logic [SUM_W-1:0]   quo;
  logic [REM_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [SUM_W-1:0]   din_u;
  logic [SUM_W-1:0]   din_mag;
  logic [REM_W:0]     trial;
  logic               fits;
  logic               rnd_up;
  logic [SUM_W:0]     qr;
  logic [DATA_WIDTH_IN-1:0] res;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // Unsigned magnitude keeps -2^(SUM_W-1) representable as 2^(SUM_W-1).
  assign din_u   = din;
  assign din_mag = din_u[SUM_W-1] ? (~din_u + SUM_W'(1)) : din_u;

  assign trial  = {rem, mag[SUM_W-1]};
  assign fits   = (trial >= DIVISOR);
  assign rnd_up = (ROUND_MODE != 0) && ({rem, 1'b0} >= DIVISOR);
  assign qr     = {1'b0, quo} + {{SUM_W{1'b0}}, rnd_up};

  // Saturation is decided on the magnitude before the sign is reapplied.
  always_comb begin
    res = '0;
    if (neg) begin
      res = (qr > NEG_LIM) ? MIN_OUT : -qr[DATA_WIDTH_IN-1:0];
    end else begin
      res = (qr > POS_LIM) ? MAX_OUT : qr[DATA_WIDTH_IN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      neg       <= 1'b0;
      mag       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg   <= din_u[SUM_W-1];
            mag   <= din_mag;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (ena) begin
            mag <= {mag[SUM_W-2:0], 1'b0};
            rem <= REM_W'(fits ? (trial - DIVISOR) : trial);
            quo <= {quo[SUM_W-2:0], fits};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(SUM_W-1)) begin
              state <= ROUND;
            end
          end
        end
        ROUND: begin
          if (ena) begin
            dout      <= res;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_normalizer.sv
// Four sum_normalizer instances (NUM_INPUT 3/4, round/truncate, 8-bit out) driven in lockstep
// and checked against an integer-arithmetic mean model.
module tb_sum_normalizer;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic in_valid;
  logic out_ready;
  logic signed [9:0] din;

  logic [3:0] ir;
  logic [3:0] ov;
  logic [3:0] bz;
  logic signed [7:0] dq [4];

  int n_tests = 0;
  int n_fail  = 0;
  int got [4];

  always #5 clk = ~clk;

  sum_normalizer #(.NUM_INPUT(3), .DATA_WIDTH_IN(8), .ROUND_MODE(1)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(ir[0]), .din(din),
    .out_valid(ov[0]), .out_ready(out_ready), .dout(dq[0]), .busy(bz[0]));
  sum_normalizer #(.NUM_INPUT(3), .DATA_WIDTH_IN(8), .ROUND_MODE(0)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(ir[1]), .din(din),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(dq[1]), .busy(bz[1]));
  sum_normalizer #(.NUM_INPUT(4), .DATA_WIDTH_IN(8), .ROUND_MODE(1)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(ir[2]), .din(din),
    .out_valid(ov[2]), .out_ready(out_ready), .dout(dq[2]), .busy(bz[2]));
  sum_normalizer #(.NUM_INPUT(4), .DATA_WIDTH_IN(8), .ROUND_MODE(0)) u3 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(ir[3]), .din(din),
    .out_valid(ov[3]), .out_ready(out_ready), .dout(dq[3]), .busy(bz[3]));

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mean of s over n, optional round-half-away-from-zero, clamped to signed 8 bits.
  function automatic int ref_mean(input int s, input int n, input bit rm);
    int m;
    int q;
    int r;
    m = (s < 0) ? -s : s;
    q = m / n;
    r = m % n;
    if (rm && (2 * r >= n)) q++;
    if (s < 0) q = -q;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int ref_for(input int i, input int s);
    return ref_mean(s, (i < 2) ? 3 : 4, (i % 2) == 0);
  endfunction

  task automatic accept(input int s);
    @(negedge clk);
    din      = 10'(s);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output int cyc, output bit bok);
    cyc = start;
    bok = 1'b1;
    while (ov[0] !== 1'b1 && cyc < 200) begin
      if (bz !== 4'hf) bok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (bz !== 4'hf) bok = 1'b0;
  endtask

  task automatic check_results(input string tag, input int s);
    for (int i = 0; i < 4; i++) begin
      got[i] = dq[i];
      check($sformatf("%s_dout_u%0d(din=%0d)", tag, i, s), dq[i], ref_for(i, s));
    end
    check({tag, "_ov_all"}, ov, 4'hf);
  endtask

  task automatic do_op(input int s, input int hold);
    int cyc;
    bit bok;
    out_ready = (hold == 0);
    accept(s);
    wait_result(0, cyc, bok);
    check("latency", cyc, 11);
    check("busy_during_op", int'(bok), 1);
    check_results("op", s);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_dout", dq[0], got[0]);
      check("hold_ov", ov, 4'hf);
      check("hold_ir", ir, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ov", ov, 0);
    check("release_ir", ir, 4'hf);
  endtask

  int vec [7]    = '{100, -101, 511, -512, 0, 6, -6};
  int lit [7][4] = '{'{33, 33, 25, 25}, '{-34, -33, -25, -25}, '{127, 127, 127, 127},
                     '{-128, -128, -128, -128}, '{0, 0, 0, 0}, '{2, 2, 2, 1}, '{-2, -2, -2, -1}};

  initial begin
    int cyc;
    bit bok;
    int snap;
    bit stale;
    int s;

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ir, 0);
    check("rst_out_valid", ov, 0);
    check("rst_busy", bz, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_dout_u%0d", i), dq[i], 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", ir, 4'hf);

    // Directed vectors, each also compared against hand-worked values.
    for (int k = 0; k < 7; k++) begin
      do_op(vec[k], 0);
      for (int i = 0; i < 4; i++)
        check($sformatf("vec_din%0d_u%0d", vec[k], i), got[i], lit[k][i]);
    end

    // Backpressure with a new din held on in_valid that must wait for release.
    out_ready = 1'b0;
    accept(200);
    wait_result(0, cyc, bok);
    check("bp_latency", cyc, 11);
    check_results("bp_first", 200);
    snap = dq[0];
    din = 10'(-300);
    in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_dout_stable", dq[0], snap);
      check("bp_in_ready_low", ir, 0);
      check("bp_ov_held", ov, 4'hf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ov", ov, 0);
    check("bp_release_ir", ir, 4'hf);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(0, cyc, bok);
    check("bp_second_latency", cyc, 11);
    check("bp_second_busy", int'(bok), 1);
    check_results("bp_second", -300);
    @(negedge clk);
    check("bp_second_release", ov, 0);

    // ena low for 4 cycles mid-division stretches latency by exactly 4.
    accept(100);
    cyc = 0;
    repeat (3) begin @(negedge clk); cyc++; end
    ena = 1'b0;
    repeat (4) begin @(negedge clk); cyc++; end
    ena = 1'b1;
    wait_result(cyc, cyc, bok);
    check("ena_latency", cyc, 15);
    check("ena_busy", int'(bok), 1);
    check("ena_dout", dq[0], 33);
    @(negedge clk);
    check("ena_release_ir", ir, 4'hf);

    // Reset mid-division discards the in-flight result.
    accept(100);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ov", ov, 0);
    check("midrst_ir", ir, 0);
    check("midrst_busy", bz, 0);
    check("midrst_dout", dq[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ir", ir, 4'hf);
    check("midrst_release_ov", ov, 0);
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov !== 4'h0 || dq[0] !== 8'sd0) stale = 1'b1;
    end
    check("midrst_no_stale", int'(stale), 0);
    do_op(77, 0);

    // Randomized sums with random consumer stalls.
    repeat (40) begin
      s = int'($urandom_range(1023)) - 512;
      do_op(s, int'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d checks run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
